// File: rtl/stream_resp_pkg.sv
// Shared types for the PE stream responder: the per-beat FIFO entry and the
// responder FSM encoding.
package stream_resp_pkg;

  localparam int unsigned BEAT_DATA_W = 16;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   is_input;
  } stream_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_INPUT,
    RD_FILTER,
    RELEASE
  } resp_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry beat FIFO that soaks up the one-cycle SRAM read latency while the
// PE is applying backpressure.
module stream_skid_fifo
  import stream_resp_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  stream_beat_t push_beat,
  input  logic         pop,
  output stream_beat_t head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  stream_beat_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_beat;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/stream_resp.sv
// PE stream-request responder: fetches the activation then weight segment from
// SRAM and streams them to the PE with per-segment finish pulses.
module stream_resp
  import stream_resp_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned K_W    = 4,
  parameter int unsigned L_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_filter_valid,
  input  logic [K_W-1:0]    req_filter_k,
  input  logic [L_W-1:0]    req_layer,
  input  logic              req_input_valid,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic [LEN_W-1:0]  wt_len,
  input  logic [ADDR_W-1:0] act_base,
  input  logic [LEN_W-1:0]  act_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              stream_valid,
  output logic [DATA_W-1:0] stream_data,
  output logic              stream_is_input,
  input  logic              stream_ready,
  output logic              Stream_input_finish_PE,
  output logic              Stream_filter_finish
);

  resp_state_t       state;
  logic [ADDR_W-1:0] act_base_q, wt_base_q, addr_q;
  logic [LEN_W-1:0]  act_len_q, wt_len_q, rd_cnt, beat_cnt, cur_len;
  logic              rd_valid_q, rd_is_input_q;
  logic              in_fin_q, flt_fin_q;
  logic              reading, can_issue, handshake, seg_done;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [1:0]        fifo_count;
  stream_beat_t      incoming, fifo_head, out_beat;
  logic              unused_req;

  // (layer, k) select the base/len table outside this block.
  assign unused_req = ^{req_filter_k, req_layer};

  assign reading   = (state == RD_INPUT) || (state == RD_FILTER);
  assign cur_len   = (state == RD_INPUT) ? act_len_q : wt_len_q;
  assign can_issue = !fifo_full && ((fifo_count + 2'(rd_valid_q)) < 2'd2);
  assign mem_rd_en = reading && (rd_cnt < cur_len) && can_issue;
  assign mem_rd_addr = addr_q;

  // Returning SRAM data bypasses the empty FIFO so the first beat appears
  // the cycle it comes back; it is only stored if the PE does not take it.
  always_comb begin
    incoming          = '0;
    incoming.data     = BEAT_DATA_W'(mem_rd_data);
    incoming.is_input = rd_is_input_q;
    out_beat          = fifo_empty ? incoming : fifo_head;
  end

  assign stream_valid    = !fifo_empty || rd_valid_q;
  assign stream_data     = stream_valid ? DATA_W'(out_beat.data) : '0;
  assign stream_is_input = stream_valid && out_beat.is_input;
  assign handshake       = stream_valid && stream_ready;
  assign fifo_push       = rd_valid_q && !(fifo_empty && stream_ready);
  assign fifo_pop        = !fifo_empty && stream_ready;

  assign seg_done = reading &&
                    ((cur_len == '0) || (handshake && (beat_cnt == cur_len - LEN_W'(1))));

  assign Stream_input_finish_PE = in_fin_q;
  assign Stream_filter_finish   = flt_fin_q;

  stream_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_beat (incoming),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      act_base_q    <= '0;
      wt_base_q     <= '0;
      act_len_q     <= '0;
      wt_len_q      <= '0;
      addr_q        <= '0;
      rd_cnt        <= '0;
      beat_cnt      <= '0;
      rd_valid_q    <= 1'b0;
      rd_is_input_q <= 1'b0;
      in_fin_q      <= 1'b0;
      flt_fin_q     <= 1'b0;
    end else begin
      rd_valid_q    <= mem_rd_en;
      rd_is_input_q <= (state == RD_INPUT);
      in_fin_q      <= 1'b0;
      flt_fin_q     <= 1'b0;
      if (mem_rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        rd_cnt <= rd_cnt + LEN_W'(1);
      end
      if (handshake) beat_cnt <= beat_cnt + LEN_W'(1);

      case (state)
        IDLE: begin
          if (req_filter_valid) begin
            act_base_q <= act_base;
            wt_base_q  <= wt_base;
            act_len_q  <= act_len;
            wt_len_q   <= wt_len;
            addr_q     <= req_input_valid ? act_base : wt_base;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
            state      <= req_input_valid ? RD_INPUT : RD_FILTER;
          end
        end
        RD_INPUT: begin
          if (seg_done) begin
            in_fin_q <= 1'b1;
            addr_q   <= wt_base_q;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            state    <= RD_FILTER;
          end
        end
        RD_FILTER: begin
          if (seg_done) begin
            flt_fin_q <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          if (!req_filter_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_resp.sv
// Directed bench for stream_resp: SRAM model returns {4'h5, addr}, every
// expected value below is hand-derived from that.
module tb_stream_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_filter_valid;
  logic [3:0]  req_filter_k;
  logic [2:0]  req_layer;
  logic        req_input_valid;
  logic [11:0] wt_base, act_base;
  logic [9:0]  wt_len, act_len;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic        stream_valid;
  logic [15:0] stream_data;
  logic        stream_is_input;
  logic        stream_ready;
  logic        Stream_input_finish_PE;
  logic        Stream_filter_finish;

  int checks = 0;
  int failures = 0;

  logic [16:0] beats[$];
  int en_cnt, first_en, first_valid, fin_in_cnt, fin_in_cyc, fin_f_cnt, fin_f_cyc;
  int beats_at_infin, unstable, max_out;

  stream_resp #(.DATA_W(16), .ADDR_W(12), .LEN_W(10), .K_W(4), .L_W(3)) u_dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_filter_valid       (req_filter_valid),
    .req_filter_k           (req_filter_k),
    .req_layer              (req_layer),
    .req_input_valid        (req_input_valid),
    .wt_base                (wt_base),
    .wt_len                 (wt_len),
    .act_base               (act_base),
    .act_len                (act_len),
    .mem_rd_en              (mem_rd_en),
    .mem_rd_addr            (mem_rd_addr),
    .mem_rd_data            (mem_rd_data),
    .stream_valid           (stream_valid),
    .stream_data            (stream_data),
    .stream_is_input        (stream_is_input),
    .stream_ready           (stream_ready),
    .Stream_input_finish_PE (Stream_input_finish_PE),
    .Stream_filter_finish   (Stream_filter_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= {4'h5, mem_rd_addr};
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs ncyc cycles after acceptance; mode 1 drives ready as 1,0,0,1,...
  task automatic watch(input int ncyc, input int mode);
    logic        stall_prev = 1'b0;
    logic [16:0] prev = '0;
    int          issued = 0;
    int          accepted = 0;
    beats.delete();
    en_cnt = 0; first_en = -1; first_valid = -1;
    fin_in_cnt = 0; fin_in_cyc = -1; fin_f_cnt = 0; fin_f_cyc = -1;
    beats_at_infin = -1; unstable = 0; max_out = 0;
    for (int n = 1; n <= ncyc; n++) begin
      cycle();
      stream_ready = (mode == 0) ? 1'b1 : ((n % 4 == 1) || (n % 4 == 0));
      #1;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (stall_prev && (!stream_valid || {stream_is_input, stream_data} != prev))
        unstable++;
      if (mem_rd_en) begin
        en_cnt++;
        issued++;
        if (first_en < 0) first_en = n;
      end
      if (stream_valid && first_valid < 0) first_valid = n;
      if (stream_valid && stream_ready) begin
        beats.push_back({stream_is_input, stream_data});
        accepted++;
      end
      if (Stream_input_finish_PE) begin
        fin_in_cnt++;
        fin_in_cyc = n;
        beats_at_infin = beats.size();
      end
      if (Stream_filter_finish) begin
        fin_f_cnt++;
        fin_f_cyc = n;
      end
      stall_prev = stream_valid && !stream_ready;
      prev = {stream_is_input, stream_data};
    end
  endtask

  initial begin
    rst = 1'b1;
    req_filter_valid = 1'b0; req_input_valid = 1'b0;
    req_filter_k = 4'd0; req_layer = 3'd0;
    wt_base = '0; wt_len = '0; act_base = '0; act_len = '0;
    stream_ready = 1'b1;
    cycle();
    cycle();
    chk("reset_ctrl", {27'd0, stream_valid, mem_rd_en, stream_is_input,
                       Stream_input_finish_PE, Stream_filter_finish}, 32'd0);
    chk("reset_addr", {20'd0, mem_rd_addr}, 32'd0);
    chk("reset_data", {16'd0, stream_data}, 32'd0);
    rst = 1'b0;
    cycle();

    // Weights only, request then held 6 cycles past the finish
    req_filter_k = 4'd2; req_layer = 3'd1;
    req_input_valid = 1'b0; wt_base = 12'h100; wt_len = 10'd4;
    req_filter_valid = 1'b1;
    watch(12, 0);
    chk("t1_first_en", first_en, 1);
    chk("t1_first_valid", first_valid, 2);
    chk("t1_nbeats", beats.size(), 4);
    for (int i = 0; i < beats.size() && i < 4; i++)
      chk("t1_beat", {15'd0, beats[i]}, {15'd0, 1'b0, 16'h5100 + 16'(i)});
    chk("t1_rd_cnt_held", en_cnt, 4);
    chk("t1_ffin_cnt", fin_f_cnt, 1);
    chk("t1_ffin_cyc", fin_f_cyc, 6);
    chk("t1_infin_cnt", fin_in_cnt, 0);
    req_filter_valid = 1'b0;
    cycle();

    // Layer-0 combined request; first_en==1 also shows the drop returned to IDLE
    req_layer = 3'd0; req_filter_k = 4'd0;
    req_input_valid = 1'b1; act_base = 12'h200; act_len = 10'd3;
    wt_base = 12'h300; wt_len = 10'd2;
    req_filter_valid = 1'b1;
    watch(14, 0);
    chk("t2_first_en", first_en, 1);
    chk("t2_nbeats", beats.size(), 5);
    if (beats.size() == 5) begin
      chk("t2_b0", {15'd0, beats[0]}, {15'd0, 17'h1_5200});
      chk("t2_b1", {15'd0, beats[1]}, {15'd0, 17'h1_5201});
      chk("t2_b2", {15'd0, beats[2]}, {15'd0, 17'h1_5202});
      chk("t2_b3", {15'd0, beats[3]}, {15'd0, 17'h0_5300});
      chk("t2_b4", {15'd0, beats[4]}, {15'd0, 17'h0_5301});
    end
    chk("t2_infin_cnt", fin_in_cnt, 1);
    chk("t2_infin_cyc", fin_in_cyc, 5);
    chk("t2_beats_before_infin", beats_at_infin, 3);
    chk("t2_ffin_cnt", fin_f_cnt, 1);
    chk("t2_ffin_cyc", fin_f_cyc, 8);
    req_filter_valid = 1'b0;
    cycle();

    // Backpressure
    req_input_valid = 1'b0; wt_base = 12'h040; wt_len = 10'd5;
    req_filter_valid = 1'b1;
    watch(30, 1);
    chk("t3_nbeats", beats.size(), 5);
    for (int i = 0; i < beats.size() && i < 5; i++)
      chk("t3_beat", {15'd0, beats[i]}, {15'd0, 1'b0, 16'h5040 + 16'(i)});
    chk("t3_stable", unstable, 0);
    chk("t3_occupancy_le2", (max_out <= 2) ? 1 : 0, 1);
    chk("t3_rd_cnt", en_cnt, 5);
    chk("t3_ffin_cnt", fin_f_cnt, 1);
    stream_ready = 1'b1;
    req_filter_valid = 1'b0;
    cycle();

    // Zero-length weight segment
    wt_base = 12'h080; wt_len = 10'd0;
    req_filter_valid = 1'b1;
    watch(6, 0);
    chk("t4_rd_cnt", en_cnt, 0);
    chk("t4_nbeats", beats.size(), 0);
    chk("t4_ffin_cyc", fin_f_cyc, 2);
    chk("t4_ffin_cnt", fin_f_cnt, 1);
    req_filter_valid = 1'b0;
    cycle();

    // Zero-length activations followed by a one-beat weight segment
    req_input_valid = 1'b1; act_base = 12'h0F0; act_len = 10'd0;
    wt_base = 12'h0A0; wt_len = 10'd1;
    req_filter_valid = 1'b1;
    watch(8, 0);
    chk("t5_infin_cyc", fin_in_cyc, 2);
    chk("t5_first_en", first_en, 2);
    chk("t5_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t5_b0", {15'd0, beats[0]}, {15'd0, 17'h0_50A0});
    chk("t5_ffin_cyc", fin_f_cyc, 4);
    req_filter_valid = 1'b0;
    cycle();

    // Reset during the second beat of a 6-beat weight segment
    req_input_valid = 1'b0; wt_base = 12'h010; wt_len = 10'd6;
    req_filter_valid = 1'b1;
    cycle();
    cycle();
    chk("t6_beat1", {15'd0, stream_valid, stream_data}, {15'd0, 17'h1_5010});
    cycle();
    chk("t6_beat2", {15'd0, stream_valid, stream_data}, {15'd0, 17'h1_5011});
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {27'd0, stream_valid, mem_rd_en, stream_is_input,
                        Stream_input_finish_PE, Stream_filter_finish}, 32'd0);
    chk("t6_rst_addr", {20'd0, mem_rd_addr}, 32'd0);
    chk("t6_rst_data", {16'd0, stream_data}, 32'd0);
    req_filter_valid = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    wt_base = 12'h020; wt_len = 10'd1;
    req_filter_valid = 1'b1;
    watch(6, 0);
    chk("t6_after_first_en", first_en, 1);
    chk("t6_after_nbeats", beats.size(), 1);
    if (beats.size() == 1) chk("t6_after_b0", {15'd0, beats[0]}, {15'd0, 17'h0_5020});
    chk("t6_after_ffin_cyc", fin_f_cyc, 3);
    req_filter_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
